// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between two byte requesters.
// Arbitrates, then holds the UART in transmit for one frame plus a guard gap.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0_valid/data/ready   requester 0 byte handshake (ready is combinational)
//   req1_valid/data/ready   requester 1 byte handshake (ready is combinational)
//   uart_idle, uart_data    registered drive of the UART IDLE and data inputs
//   grant                   one-hot owner of the current frame, 00 when idle
//   busy                    high while a frame or its gap is in progress
//
// Build option: define UART_SCHED_RR_EN for round-robin tie breaking;
// otherwise requester 0 has fixed priority.
module uart_tx_scheduler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_BITS   = 11,
    parameter int GAP_BITS     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       uart_idle,
    output logic [7:0] uart_data,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int SEND_N = FRAME_BITS * CLKS_PER_BIT;
    localparam int GAP_N  = GAP_BITS * CLKS_PER_BIT;
    localparam int MAX_B  = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
    localparam int CW     = $clog2(MAX_B * CLKS_PER_BIT + 1);

    localparam logic [CW-1:0] SEND_LAST = CW'(SEND_N - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    grant_q, grant_d;
    logic          idle_q, idle_d;
    logic          busy_q, busy_d;
    logic          last_q, last_d;

    logic tie_to_1;
    logic pick0, pick1;
    logic accept;

    // last_q holds the index of the most recently accepted requester.
`ifdef UART_SCHED_RR_EN
    assign tie_to_1 = ~last_q;
`else
    logic last_unused;
    assign tie_to_1    = 1'b0;
    assign last_unused = last_q;
`endif

    assign pick1 = req1_valid & (~req0_valid | tie_to_1);
    assign pick0 = req0_valid & ~pick1;

    // Gated by rst_n so no handshake completes while reset is asserted.
    assign req0_ready = rst_n & (state_q == ST_IDLE) & pick0;
    assign req1_ready = rst_n & (state_q == ST_IDLE) & pick1;
    assign accept     = req0_ready | req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            grant_q <= 2'b00;
            idle_q  <= 1'b1;
            busy_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            idle_q  <= idle_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = grant_q;
        idle_d  = idle_q;
        busy_d  = busy_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                    data_d  = pick1 ? req1_data : req0_data;
                    grant_d = {pick1, pick0};
                    last_d  = pick1;
                    idle_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SEND: begin
                if (cnt_q == SEND_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    idle_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                grant_d = 2'b00;
                idle_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign uart_idle = idle_q;
    assign uart_data = data_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: directed scenarios plus random traffic,
// checked every cycle against a frame-timing reference model.
module tb_uart_tx_scheduler;

    localparam int CPB    = 4;
    localparam int FB     = 11;
    localparam int GB     = 1;
    localparam int SEND_N = FB * CPB;
    localparam int GAP_N  = GB * CPB;
    localparam int PERIOD = SEND_N + GAP_N + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       uart_idle;
    logic [7:0] uart_data;
    logic [1:0] grant;
    logic       busy;

    uart_tx_scheduler #(
        .CLKS_PER_BIT(CPB),
        .FRAME_BITS  (FB),
        .GAP_BITS    (GB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .uart_idle (uart_idle),
        .uart_data (uart_data),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] d;
    } acc_t;

    acc_t accq[$];

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         m_act = 1'b0;
    int         m_acc = 0;
    logic [1:0] m_own = 2'b00;
    logic [7:0] m_data = 8'h00;
    bit         m_last = 1'b1;
    bit         r0_seen, r1_seen;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, compare with model, advance model,
    // return at posedge+1 so the caller may drive new inputs.
    task automatic tick();
        int  phase;
        bit  in_frame, in_send, idle_st, tie1, w0, w1;
        @(negedge clk);
        phase    = m_act ? (cyc - m_acc) : 100000;
        in_send  = (phase >= 1) && (phase <= SEND_N);
        in_frame = (phase >= 1) && (phase <= SEND_N + GAP_N);
        idle_st  = !in_frame && rst_n;
`ifdef UART_SCHED_RR_EN
        tie1 = (m_last == 1'b0);
`else
        tie1 = 1'b0;
`endif
        w1 = idle_st && req1_valid && (!req0_valid || tie1);
        w0 = idle_st && req0_valid && !w1;
        chk("uart_idle", uart_idle, !in_send);
        chk("busy", busy, in_frame);
        chk("grant", grant, in_frame ? m_own : 2'b00);
        chk("uart_data", uart_data, m_data);
        chk("req0_ready", req0_ready, w0);
        chk("req1_ready", req1_ready, w1);
        r0_seen = req0_ready;
        r1_seen = req1_ready;
        if (req0_ready) accq.push_back('{cyc, req0_data});
        if (req1_ready) accq.push_back('{cyc, req1_data});
        if (w0 || w1) begin
            m_act  = 1'b1;
            m_acc  = cyc;
            m_own  = w1 ? 2'b10 : 2'b01;
            m_data = w1 ? req1_data : req0_data;
            m_last = w1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_idle", uart_idle, 1'b1);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", uart_data, 8'h00);
        chk("rst_rdy", {req1_ready, req0_ready}, 2'b00);
        m_act  = 1'b0;
        m_own  = 2'b00;
        m_data = 8'h00;
        m_last = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send0(input logic [7:0] d);
        req0_valid = 1'b1;
        req0_data  = d;
        tick();
        req0_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_d;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Single byte
        accq.delete();
        send0(8'hA5);
        repeat (PERIOD + 2) tick();
        chk("a5_count", accq.size(), 1);
        if (accq.size() >= 1) chk("a5_data", accq[0].d, 8'hA5);

        // Contention from a fresh reset
        apply_reset();
        accq.delete();
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        req1_valid = 1'b1;
        req1_data  = 8'h22;
        repeat (3 * PERIOD + 3) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (PERIOD + 2) tick();
        chk("cont_count", accq.size(), 4);
        for (int k = 0; k < 4 && k < accq.size(); k++) begin
`ifdef UART_SCHED_RR_EN
            exp_d = (k % 2 == 0) ? 8'h11 : 8'h22;
`else
            exp_d = 8'h11;
`endif
            chk("cont_data", accq[k].d, exp_d);
            if (k > 0) chk("cont_spacing", accq[k].c - accq[k-1].c, PERIOD);
        end

        // Ready suppression while a frame is in flight
        accq.delete();
        send0(8'h77);
        repeat (10) tick();
        req1_valid = 1'b1;
        req1_data  = 8'h3C;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            if (r1_seen) break;
        end
        req1_valid = 1'b0;
        repeat (PERIOD + 2) tick();
        chk("sup_count", accq.size(), 2);
        if (accq.size() == 2) begin
            chk("sup_data", accq[1].d, 8'h3C);
            chk("sup_spacing", accq[1].c - accq[0].c, PERIOD);
        end

        // Reset in the middle of a frame
        accq.delete();
        send0(8'h5A);
        repeat (19) tick();
        apply_reset();
        repeat (PERIOD + 10) tick();
        chk("midrst_count", accq.size(), 1);

        // Valid pulse that never spans a clock edge, during GAP
        accq.delete();
        send0(8'h96);
        repeat (SEND_N + 1) tick();
        req0_data  = 8'hC3;
        req0_valid = 1'b1;
        #1;
        chk("wd_ready", req0_ready, 1'b0);
        chk("wd_idle", uart_idle, 1'b1);
        req0_valid = 1'b0;
        repeat (PERIOD + 10) tick();
        chk("wd_count", accq.size(), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (req0_valid && r0_seen) req0_valid = 1'b0;
            if (req1_valid && r1_seen) req1_valid = 1'b0;
            if (req0_valid && $urandom_range(15) == 0) req0_valid = 1'b0;
            else if (!req0_valid && $urandom_range(7) == 0) begin
                req0_valid = 1'b1;
                req0_data  = 8'($urandom);
            end
            if (req1_valid && $urandom_range(15) == 0) req1_valid = 1'b0;
            else if (!req1_valid && $urandom_range(7) == 0) begin
                req1_valid = 1'b1;
                req1_data  = 8'($urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
